// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, access owner and a
// counter-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants made while fetch is waiting;
// at_limit tells the arbiter to hand the next slot to fetch.
module arb_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                inc,
  input  logic                                clr,
  output logic                                at_limit,
  output logic [cnt_width(STARVE_LIMIT)-1:0]  count
);

  localparam int CW = cnt_width(STARVE_LIMIT);

  assign at_limit = (count == CW'(STARVE_LIMIT));

  // Clear wins over increment; the count sticks at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-ported memory: data
// first, fetch forced through after STARVE_LIMIT consecutive data wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  f_req_i,
  input  logic [ADDR_WIDTH-1:0] f_addr_i,
  output logic                  f_gnt_o,
  output logic                  f_done_o,
  output logic [DATA_WIDTH-1:0] f_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_done_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int LAT_W = cnt_width(MEM_LAT - 1);

  arb_state_t                        state;
  arb_state_t                        state_nxt;
  arb_owner_t                        owner;
  logic                              acc_we;
  logic [LAT_W-1:0]                  lat_cnt;
  logic                              lat_zero;
  logic                              arb_en;
  logic                              at_limit;
  logic                              f_gnt;
  logic                              d_gnt;
  logic                              any_gnt;
  logic [cnt_width(STARVE_LIMIT)-1:0] starve_count;

  assign lat_zero = (lat_cnt == '0);

  // Reset also blocks grants so nothing is accepted while rst_i is high.
  always_comb begin
    arb_en  = !rst_i && ((state == IDLE) || (state == DONE));
    d_gnt   = arb_en && d_req_i && !(at_limit && f_req_i);
    f_gnt   = arb_en && f_req_i && !d_gnt;
    any_gnt = d_gnt || f_gnt;
  end

  assign f_gnt_o = f_gnt;
  assign d_gnt_o = d_gnt;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk_i),
    .rst      (rst_i),
    .inc      (d_gnt && f_req_i),
    .clr      (f_gnt || (d_gnt && !f_req_i)),
    .at_limit (at_limit),
    .count    (starve_count)
  );

  // Next-state decode; DONE re-arbitrates so accesses can run back to back.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_gnt) state_nxt = ACCESS;
        else         state_nxt = IDLE;
      end
      ACCESS: begin
        if (lat_zero) state_nxt = DONE;
        else          state_nxt = ACCESS;
      end
      DONE: begin
        if (any_gnt) state_nxt = ACCESS;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Access latch, memory bus, latency count, read capture and done pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner       <= OWNER_FETCH;
      acc_we      <= 1'b0;
      lat_cnt     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      f_rdata_o   <= '0;
      d_rdata_o   <= '0;
      f_done_o    <= 1'b0;
      d_done_o    <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      f_done_o <= (state == ACCESS) && lat_zero && (owner == OWNER_FETCH);
      d_done_o <= (state == ACCESS) && lat_zero && (owner == OWNER_DATA);
      if (any_gnt) begin
        owner      <= d_gnt ? OWNER_DATA : OWNER_FETCH;
        acc_we     <= d_gnt && d_we_i;
        mem_we_o   <= d_gnt && d_we_i;
        mem_addr_o <= d_gnt ? d_addr_i : f_addr_i;
        lat_cnt    <= LAT_W'(MEM_LAT - 1);
        if (d_gnt) mem_wdata_o <= d_wdata_i;
        else       mem_wdata_o <= mem_wdata_o;
      end else if (state == ACCESS) begin
        if (!lat_zero) begin
          lat_cnt <= lat_cnt - LAT_W'(1);
        end else if (owner == OWNER_FETCH) begin
          f_rdata_o <= mem_rdata_i;
        end else if (!acc_we) begin
          d_rdata_o <= mem_rdata_i;
        end else begin
          d_rdata_o <= d_rdata_o;
        end
      end else begin
        lat_cnt <= lat_cnt;
      end
    end
  end

endmodule
